screen_sequencer: RTL
=====================

# screen_sequencer

Top-level screen-mode controller for the Snake display path. It decides which full-screen image is drawn (title, flashing title, black clear, game-over red) and when the game logic runs. For each sweep it generates the pixel address, the x/y coordinates and the VGA plot strobe. It sits between the key/game logic and the full-screen image drawer, and it owns the drawer's address counter.

## Interface
Parameters:
- `WIDTH`, 160, screen width in pixels
- `HEIGHT`, 120, screen height in pixels
- `FLASH_PERIOD`, 25_000_000, clock cycles between flash-phase toggles on the title screen

Ports:
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  synchronous start key, level
- `game_over`  in  1  one-cycle pulse from game logic
- `address`  out  15  image RAM read address, y*WIDTH+x
- `x`  out  8  pixel column, aligned with RAM data
- `y`  out  7  pixel row, aligned with RAM data
- `plot`  out  1  VGA write enable
- `show_title`, `show_black`, `show_gameover`, `flash`  out  1 each  drawer mode selects, at most one high
- `game_en`  out  1  game logic run enable
- `sweep_done`  out  1  one-cycle pulse on the final pixel of a sweep

## Operation
State machine:
- `TITLE_DRAW`: sweep with `show_title`. On completion, go to `TITLE_WAIT`.
- `TITLE_WAIT`: flash timer counts up.
  - At `FLASH_PERIOD-1`: timer clears, phase toggles, go to `FLASH_DRAW`.
  - If `start_pend` is set: go to `BLACK_DRAW` (takes priority over the timer).
- `FLASH_DRAW`: sweep with `flash` when phase=1, or with `show_title` when phase=0. On completion, go to `TITLE_WAIT`.
- `BLACK_DRAW`: sweep with `show_black`. On completion, go to `PLAY`.
- `PLAY`: `game_en`=1, no plotting. On `game_over`, go to `OVER_DRAW`.
- `OVER_DRAW`: sweep with `show_gameover`. On completion, go to `OVER_WAIT`.
- `OVER_WAIT`: idle. On `start` rising edge, phase clears and go to `TITLE_DRAW`.

Start handling:
- Rising-edge detect on `start` (registered previous value).
- Edges seen in `TITLE_DRAW`, `TITLE_WAIT` or `FLASH_DRAW` set `start_pend`. The flag is consumed in `TITLE_WAIT`, so a sweep in progress always finishes first.
- `start_pend` clears on entry to `BLACK_DRAW`.
- A start edge in `PLAY`, `BLACK_DRAW` or `OVER_DRAW` is ignored.
- `game_over` outside `PLAY` is ignored.

Sweep:
- x/y counters, no divide or modulo. x runs 0..WIDTH-1, then y increments.
- `address` is a separate incrementing counter running 0..WIDTH*HEIGHT-1 (19199).
- Counters and `address` reset to 0 at each sweep start.
- Mode selects are asserted for the whole sweep, including the pipeline tail cycle.

## Timing
- Reset values:
  - state=`TITLE_DRAW`; `address`, `x`, `y` = 0.
  - `plot`, `game_en`, `sweep_done`, `flash`, `show_black`, `show_gameover` = 0; `show_title`=1.
  - phase=0; timer=0; `start_pend`=0.
- Reset is asynchronous and wins in any state. Reset mid-sweep restarts the title sweep from `address`=0 on the first clock after release.
- The image RAM has 1-cycle read latency:
  - `address` is issued in cycle n.
  - `x`, `y` and `plot`=1 appear in cycle n+1, registered together with the RAM `q`.
- A sweep therefore asserts `plot` for exactly 19200 consecutive cycles, starting 1 cycle after the state is entered.
- `sweep_done` coincides with the last `plot` cycle (x=159, y=119).
- The state leaves the draw state on the cycle after `sweep_done`.
- Latencies:
  - `game_en` rises 1 cycle after the `BLACK_DRAW` `sweep_done`.
  - `game_en` falls the cycle after `game_over` is sampled.
- The flash timer runs only in `TITLE_WAIT` and holds its value during `FLASH_DRAW`.
- Timer width is `$clog2(FLASH_PERIOD)`.

## Test plan
- **Reset then idle:** release `rst` → `plot` high 19200 cycles; first plot x=0,y=0; last plot x=159,y=119 with `sweep_done`=1; then `TITLE_WAIT`, `plot`=0.
- **Flash cadence (`FLASH_PERIOD`=100):**
  - Expected: `FLASH_DRAW` with `flash`=1 entered 100 cycles after entering `TITLE_WAIT`.
  - Next flash sweep uses `show_title`, phase 0.
  - Phases alternate.
- **Start mid-sweep:** start edge at `address`=5000 of `TITLE_DRAW` → sweep completes to 19199; 1 cycle in `TITLE_WAIT`; `BLACK_DRAW` sweep; `game_en`=1 1 cycle after its `sweep_done`.
- **Game over:**
  - `game_over` pulse in `PLAY` → `game_en`=0 next cycle; red sweep with `show_gameover`; then `OVER_WAIT`.
  - A second `game_over` during the sweep has no effect.
  - A start edge → `TITLE_DRAW` with phase=0.
- **Ignored events:** `game_over` in `TITLE_WAIT` and start edges held in `PLAY` → no state change; `start` held high across entry to `OVER_WAIT` does not restart until released and pressed again.
- **Async reset mid-`OVER_DRAW`:** `rst` low at `address`=12345 → `plot` and `show_gameover` drop immediately; after release, title sweep starts at `address` 0.

Source files
------------

// File: rtl/screen_sequencer.sv
// Screen-mode sequencer for the Snake display path: picks which full-screen image
// is swept (title, flash, black, game-over), gates the game logic, and drives the sweep.
module screen_sequencer #(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 120,
  parameter int FLASH_PERIOD = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        game_over,
  output logic [14:0] address,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        plot,
  output logic        show_title,
  output logic        show_black,
  output logic        show_gameover,
  output logic        flash,
  output logic        game_en,
  output logic        sweep_done
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int TW   = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [14:0]   ADDR_LAST = 15'(NPIX - 1);
  localparam logic [7:0]    X_LAST    = 8'(WIDTH - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(FLASH_PERIOD - 1);

  typedef enum logic [2:0] {
    TITLE_DRAW, TITLE_WAIT, FLASH_DRAW, BLACK_DRAW, PLAY, OVER_DRAW, OVER_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          phase_q, phase_d;
  logic          pend_q, pend_d;
  logic          start_prev_q;
  logic [14:0]   addr_q, addr_d;
  logic [7:0]    xc_q, xc_d;
  logic [6:0]    yc_q, yc_d;
  logic          fin_q, fin_d;
  logic          plot_q, plot_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          done_q, done_d;
  logic          title_q, title_d;
  logic          flash_q, flash_d;
  logic          black_q, black_d;
  logic          over_q, over_d;
  logic          game_en_q, game_en_d;

  logic start_edge;
  logic drawing;

  assign start_edge = start & ~start_prev_q;
  assign drawing    = state_q inside {TITLE_DRAW, FLASH_DRAW, BLACK_DRAW, OVER_DRAW};

  // Mode sequencing; a pending start is only honoured from TITLE_WAIT so sweeps finish.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    if (start_edge && (state_q inside {TITLE_DRAW, TITLE_WAIT, FLASH_DRAW}))
      pend_d = 1'b1;
    case (state_q)
      TITLE_DRAW, FLASH_DRAW: if (done_q) state_d = TITLE_WAIT;
      TITLE_WAIT: begin
        if (pend_q) begin
          state_d = BLACK_DRAW;
          pend_d  = 1'b0;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = FLASH_DRAW;
          timer_d = '0;
          phase_d = ~phase_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      BLACK_DRAW: if (done_q) state_d = PLAY;
      PLAY:       if (game_over) state_d = OVER_DRAW;
      OVER_DRAW:  if (done_q) state_d = OVER_WAIT;
      OVER_WAIT: begin
        if (start_edge) begin
          state_d = TITLE_DRAW;
          phase_d = 1'b0;
        end
      end
      default: state_d = TITLE_DRAW;
    endcase
  end

  // Mode selects are registered from the next state so they line up with state_q.
  always_comb begin
    title_d   = (state_d == TITLE_DRAW) || ((state_d == FLASH_DRAW) && !phase_d);
    flash_d   = (state_d == FLASH_DRAW) && phase_d;
    black_d   = (state_d == BLACK_DRAW);
    over_d    = (state_d == OVER_DRAW);
    game_en_d = (state_d == PLAY);
  end

  // Address is issued one cycle ahead of x/y/plot to match the RAM read latency.
  always_comb begin
    addr_d = addr_q;
    xc_d   = xc_q;
    yc_d   = yc_q;
    fin_d  = fin_q;
    plot_d = 1'b0;
    done_d = 1'b0;
    x_d    = x_q;
    y_d    = y_q;
    if (!drawing) begin
      addr_d = '0;
      xc_d   = '0;
      yc_d   = '0;
      fin_d  = 1'b0;
    end else if (!fin_q) begin
      plot_d = 1'b1;
      x_d    = xc_q;
      y_d    = yc_q;
      if (addr_q == ADDR_LAST) begin
        done_d = 1'b1;
        fin_d  = 1'b1;
      end else begin
        addr_d = addr_q + 15'd1;
        if (xc_q == X_LAST) begin
          xc_d = '0;
          yc_d = yc_q + 7'd1;
        end else begin
          xc_d = xc_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= TITLE_DRAW;
      timer_q      <= '0;
      phase_q      <= 1'b0;
      pend_q       <= 1'b0;
      start_prev_q <= 1'b0;
      addr_q       <= '0;
      xc_q         <= '0;
      yc_q         <= '0;
      fin_q        <= 1'b0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      done_q       <= 1'b0;
      title_q      <= 1'b1;
      flash_q      <= 1'b0;
      black_q      <= 1'b0;
      over_q       <= 1'b0;
      game_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      start_prev_q <= start;
      addr_q       <= addr_d;
      xc_q         <= xc_d;
      yc_q         <= yc_d;
      fin_q        <= fin_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      done_q       <= done_d;
      title_q      <= title_d;
      flash_q      <= flash_d;
      black_q      <= black_d;
      over_q       <= over_d;
      game_en_q    <= game_en_d;
    end
  end

  assign address       = addr_q;
  assign x             = x_q;
  assign y             = y_q;
  assign plot          = plot_q;
  assign sweep_done    = done_q;
  assign show_title    = title_q;
  assign flash         = flash_q;
  assign show_black    = black_q;
  assign show_gameover = over_q;
  assign game_en       = game_en_q;

endmodule
